// File: rtl/stoplight_pkg.sv
// stoplight_pkg: shared state and lamp types for the stoplight controller
package stoplight_pkg;
  typedef enum logic [2:0] {NS_GRN, NS_YEL, RED_A, EW_GRN, EW_YEL, RED_B} light_state_t;
  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;
  function automatic light_state_t next_state(input light_state_t s);
    return s == RED_B ? NS_GRN : light_state_t'(s + 3'd1);
  endfunction
endpackage

// File: rtl/stoplight_ctrl_phase_timer.sv
// phase_timer: per-state cycle counter, cleared synchronously on every state change
module phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= '0;
    else count <= clr ? '0 : count + 1'b1;
endmodule

// File: rtl/stoplight_ctrl.sv
// stoplight_ctrl: sensor-actuated two-road intersection controller with all-red clearance.
// Optional pedestrian walk phase enabled by defining PED_WALK_EN.
module stoplight_ctrl import stoplight_pkg::*; #(
  parameter int TIMER_W      = 5,
  parameter int NS_MIN_GREEN = 8,
  parameter int NS_MAX_GREEN = 20,
  parameter int NS_YELLOW    = 3,
  parameter int EW_GREEN     = 6,
  parameter int EW_YELLOW    = 3,
  parameter int ALL_RED      = 2,
  parameter int PED_WALK     = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ew_car_present,
`ifdef PED_WALK_EN
  input  logic ped_req,
  output logic ped_walk,
`endif
  output logic northsouth_red,
  output logic northsouth_yellow,
  output logic northsouth_green,
  output logic eastwest_red,
  output logic eastwest_yellow,
  output logic eastwest_green
);
  localparam int DMAX = 2 ** TIMER_W;
  localparam logic [TIMER_W-1:0] T_NS_MIN = TIMER_W'(NS_MIN_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_NS_MAX = TIMER_W'(NS_MAX_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_NS_YEL = TIMER_W'(NS_YELLOW - 1);
  localparam logic [TIMER_W-1:0] T_EW_GRN = TIMER_W'(EW_GREEN - 1);
  localparam logic [TIMER_W-1:0] T_EW_YEL = TIMER_W'(EW_YELLOW - 1);
  localparam logic [TIMER_W-1:0] T_RED    = TIMER_W'(ALL_RED - 1);
  if (NS_MIN_GREEN < 1 || NS_MAX_GREEN < 1 || NS_YELLOW < 1 || EW_GREEN < 1 ||
      EW_YELLOW < 1 || ALL_RED < 1 || PED_WALK < 1) begin : g_bad_min
    $fatal(1, "stoplight_ctrl: every duration must be at least 1");
  end
  if (NS_MIN_GREEN > NS_MAX_GREEN) begin : g_bad_green
    $fatal(1, "stoplight_ctrl: NS_MIN_GREEN exceeds NS_MAX_GREEN");
  end
  if (NS_MAX_GREEN > DMAX || NS_YELLOW > DMAX || EW_GREEN > DMAX ||
      EW_YELLOW > DMAX || ALL_RED > DMAX || PED_WALK > DMAX) begin : g_bad_width
    $fatal(1, "stoplight_ctrl: a duration does not fit TIMER_W");
  end
  light_state_t state;
  logic [TIMER_W-1:0] timer;
  logic last, enter_ew, ew_req_q, ew_any;
  lamp_t ns, ew;
  phase_timer #(.W(TIMER_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (last),
    .count  (timer)
  );
`ifdef PED_WALK_EN
  localparam int WALK_N = PED_WALK < EW_GREEN ? PED_WALK : EW_GREEN;
  localparam logic [TIMER_W:0] T_WALK = (TIMER_W + 1)'(WALK_N);
  logic ped_req_q, walk;
  assign ew_any   = ew_req_q | ew_car_present | ped_req_q;
  assign ped_walk = state == EW_GRN && walk && {1'b0, timer} < T_WALK;
`else
  assign ew_any = ew_req_q | ew_car_present;
`endif
  assign last = state == NS_GRN ? (timer == T_NS_MAX || (timer >= T_NS_MIN && ew_any)) :
                state == NS_YEL ? timer == T_NS_YEL :
                state == EW_GRN ? timer == T_EW_GRN :
                state == EW_YEL ? timer == T_EW_YEL : timer == T_RED;
  assign enter_ew = state == RED_A && last;
  // request latches clear on EW_GRN entry; the clear beats a same-cycle set
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= NS_GRN;
      ew_req_q <= 1'b0;
`ifdef PED_WALK_EN
      ped_req_q <= 1'b0;
      walk      <= 1'b0;
`endif
    end else begin
      if (last) state <= next_state(state);
      ew_req_q <= enter_ew ? 1'b0 : ew_req_q | (ew_car_present && state != EW_GRN);
`ifdef PED_WALK_EN
      ped_req_q <= enter_ew ? 1'b0 : ped_req_q | (ped_req && state != EW_GRN);
      if (enter_ew) walk <= ped_req_q;
`endif
    end
  assign ns = '{red: state != NS_GRN && state != NS_YEL, yellow: state == NS_YEL, green: state == NS_GRN};
  assign ew = '{red: state != EW_GRN && state != EW_YEL, yellow: state == EW_YEL, green: state == EW_GRN};
  assign northsouth_red    = ns.red;
  assign northsouth_yellow = ns.yellow;
  assign northsouth_green  = ns.green;
  assign eastwest_red      = ew.red;
  assign eastwest_yellow   = ew.yellow;
  assign eastwest_green    = ew.green;
endmodule

// File: doc/stoplight_ctrl.md
Name: stoplight_ctrl

Overview:
- Parametrised, sensor-actuated two-road intersection controller; successor to the fixed-timing four-state stoplight.
- Adds configurable phase durations, NS min/max green with an EW vehicle-request latch, and all-red clearance phases.
- Timer clear is fully synchronous.
- Drives the six lamp outputs of the intersection top level directly; optional pedestrian walk phase.

Parameters:
- TIMER_W, 5, timer width; must hold max(all durations)-1.
- NS_MIN_GREEN, 8, minimum NS green cycles.
- NS_MAX_GREEN, 20, NS green cycles when no EW request arrives.
- NS_YELLOW, 3, NS yellow cycles.
- EW_GREEN, 6, EW green cycles (fixed).
- EW_YELLOW, 3, EW yellow cycles.
- ALL_RED, 2, all-red clearance cycles after each yellow.
- PED_WALK, 4, walk cycles; used only with PED_WALK_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- ew_car_present  in  1  EW vehicle sensor, synchronous to clk
- ped_req  in  1  pedestrian button, synchronous; present only with PED_WALK_EN
- northsouth_red/_yellow/_green  out  1 each  NS lamps
- eastwest_red/_yellow/_green  out  1 each  EW lamps
- ped_walk  out  1  walk lamp for crossing NS road; present only with PED_WALK_EN

Behaviour:
- States: NS_GRN, NS_YEL, RED_A, EW_GRN, EW_YEL, RED_B. Cycle order is fixed: NS_GRN -> NS_YEL -> RED_A -> EW_GRN -> EW_YEL -> RED_B -> NS_GRN.
- Reset (async assert, sync-clock release):
  - state = NS_GRN, timer = 0, ew_req_q = 0.
  - Outputs: northsouth_green = 1, eastwest_red = 1, all other lamps 0.
  - Reset mid-phase aborts immediately to these values.
- Timer:
  - Cleared to 0 on the clock edge of every state change; otherwise increments by 1.
  - Value is 0 in the first cycle of each state.
  - No wrap is possible, since every exit fires at or before DUR-1.
- Fixed-duration states (NS_YEL, RED_A, EW_GRN, EW_YEL, RED_B) exit when timer == DUR-1, so each lasts exactly DUR cycles.
- NS_GRN exits when either:
  - timer == NS_MAX_GREEN-1, or
  - timer >= NS_MIN_GREEN-1 and (ew_req_q | ew_car_present).
  - Both exit conditions true in the same cycle: a single exit.
- ew_req_q latch:
  - Set when ew_car_present = 1 in any state except EW_GRN.
  - Cleared on the edge entering EW_GRN; clear wins over a simultaneous set.
  - Sensor activity during EW_GRN is ignored.
- Lamp outputs are decoded combinationally from state, with exactly one lamp per direction lit:
  - NS green in NS_GRN, NS yellow in NS_YEL, NS red otherwise.
  - EW green in EW_GRN, EW yellow in EW_YEL, EW red otherwise.
  - Both reds in RED_A and RED_B.
- Never both directions non-red simultaneously.
- Elaboration-time checks (fatal):
  - all durations >= 1;
  - NS_MIN_GREEN <= NS_MAX_GREEN;
  - every duration <= 2**TIMER_W.

Optional Feature:
- Macro PED_WALK_EN.
- When defined:
  - ped_req and ped_walk ports exist.
  - A ped_req_q latch sets on ped_req in any state except EW_GRN.
  - ped_req_q also counts as an EW request in the NS_GRN exit term.
  - On entry to EW_GRN, a walk flag captures ped_req_q and ped_req_q clears.
  - ped_walk = 1 while in EW_GRN with walk flag set and timer < min(PED_WALK, EW_GREEN); 0 otherwise and at reset.
- When undefined: ports absent; behaviour is identical to the ped_req = 0 case.

Decomposition:
- Package stoplight_pkg holds:
  - typedef enum logic [2:0] light_state_t (six states);
  - lamp struct typedef {red, yellow, green}.
- Natural sub-module: phase_timer.
  - TIMER_W-bit counter with synchronous clear, async reset_n.
  - Instantiated once.

Test Plan:
- Reset, ew_car_present held 0:
  - NS green 20, NS yellow 3, all-red 2, EW green 6, EW yellow 3, all-red 2 cycles;
  - period 36, repeating.
- One-cycle ew_car_present pulse at cycle 2 after reset release -> NS green lasts 8 cycles (exit at timer 7); ew_req_q clears on EW_GRN entry.
- ew_car_present pulse while NS_GRN timer = 12 -> NS green lasts exactly 13 cycles.
- ew_car_present held 1 continuously -> NS green 8 cycles every phase; period 24; pulses during EW_GRN have no effect on the next NS green (20 cycles).
- Assert reset_n low mid-EW_GRN (timer = 3):
  - same cycle: northsouth_green = 1, eastwest_red = 1, latch = 0;
  - after release, first NS green lasts 20 cycles.
- PED_WALK_EN, ped_req pulse in NS_GRN at timer 1:
  - NS green 8 cycles;
  - ped_walk high for the first 4 EW_GRN cycles;
  - next EW_GRN without a request has ped_walk = 0.
- All scenarios: assertion that exactly one lamp per direction is lit and at least one direction is red.
